// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FETCH/DECODE/EXEC/MEM/WB sequencer; BR 3, R/I/STORE 4, LOAD 5 cycles at zero wait.
// Waits on imem/dmem ready with a timeout trap; stall_in freezes DECODE/EXEC/WB only, never a memory handshake.
module multicycle_ctrl #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             branch_taken,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             stall_in,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             PCSrc,
   output logic             Branch,
   output logic             MemRead,
   output logic             MemtoReg,
   output logic             MemWrite,
   output logic             ALUSrc,
   output logic             RegWrite,
   output logic [1:0]       ALUOp,
   output logic [CNT_W-1:0] instret,
   output logic             illegal,
   output logic             mem_timeout,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      C_R     = 3'd0,
      C_I     = 3'd1,
      C_LOAD  = 3'd2,
      C_STORE = 3'd3,
      C_BR    = 3'd4
   } cls_e;

   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   state_e           r_state;
   state_e           w_next;
   cls_e             r_cls;
   cls_e             w_dec_cls;
   logic             w_dec_ok;
   logic             w_ready;
   logic             w_expire;
   logic             w_hold;
   logic             w_retire;
   logic             w_set_ill;
   logic             w_set_tmo;
   logic [7:0]       r_wait;
   logic [CNT_W-1:0] r_instret;
   logic             r_illegal;
   logic             r_tmo;

   always_comb begin
      w_dec_ok  = 1'b1;
      w_dec_cls = C_R;
      case (opcode)
         7'b0110011: w_dec_cls = C_R;
         7'b0010011: w_dec_cls = C_I;
         7'b0000011: w_dec_cls = C_LOAD;
         7'b0100011: w_dec_cls = C_STORE;
         7'b1100011: w_dec_cls = C_BR;
         default:    w_dec_ok  = 1'b0;
      endcase
   end

   // The limit cycle only trips when ready is still low, so a late ready wins.
   assign w_ready  = (r_state == S_FETCH) ? imem_ready : dmem_ready;
   assign w_expire = !w_ready && (r_wait == TMO_LAST);
   assign w_hold   = stall_in && (r_state == S_DECODE || r_state == S_EXEC || r_state == S_WB);

   always_comb begin
      w_next    = r_state;
      w_retire  = 1'b0;
      w_set_ill = 1'b0;
      w_set_tmo = 1'b0;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCSrc     = 1'b0;
      Branch    = 1'b0;
      MemRead   = 1'b0;
      MemtoReg  = 1'b0;
      MemWrite  = 1'b0;
      ALUSrc    = 1'b0;
      RegWrite  = 1'b0;
      ALUOp     = 2'b00;
      case (r_state)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               IRWrite = 1'b1;
               w_next  = S_DECODE;
            end else if (w_expire) begin
               w_set_tmo = 1'b1;
               w_next    = S_TRAP;
            end
         end
         S_DECODE: begin
            if (w_dec_ok) begin
               w_next = S_EXEC;
            end else begin
               w_set_ill = 1'b1;
               w_next    = S_TRAP;
            end
         end
         S_EXEC: begin
            case (r_cls)
               C_R:     begin ALUOp = 2'b10; w_next = S_WB; end
               C_I:     begin ALUSrc = 1'b1; ALUOp = 2'b10; w_next = S_WB; end
               C_LOAD,
               C_STORE: begin ALUSrc = 1'b1; w_next = S_MEM; end
               C_BR: begin
                  ALUOp    = 2'b01;
                  Branch   = 1'b1;
                  PCWrite  = 1'b1;
                  PCSrc    = branch_taken;
                  w_retire = 1'b1;
                  w_next   = S_FETCH;
               end
               default: w_next = S_TRAP;
            endcase
         end
         S_MEM: begin
            dmem_req = 1'b1;
            ALUSrc   = 1'b1;
            MemRead  = (r_cls == C_LOAD);
            MemWrite = (r_cls == C_STORE);
            if (dmem_ready) begin
               if (r_cls == C_LOAD) begin
                  w_next = S_WB;
               end else begin
                  PCWrite  = 1'b1;
                  w_retire = 1'b1;
                  w_next   = S_FETCH;
               end
            end else if (w_expire) begin
               w_set_tmo = 1'b1;
               w_next    = S_TRAP;
            end
         end
         S_WB: begin
            RegWrite = 1'b1;
            MemtoReg = (r_cls == C_LOAD);
            PCWrite  = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
         end
         S_TRAP:  w_next = S_TRAP;
         default: w_next = S_TRAP;
      endcase
      if (w_hold) begin
         w_next    = r_state;
         w_retire  = 1'b0;
         w_set_ill = 1'b0;
         IRWrite   = 1'b0;
         PCWrite   = 1'b0;
         RegWrite  = 1'b0;
         MemWrite  = 1'b0;
         MemRead   = 1'b0;
         Branch    = 1'b0;
      end
      // Reset is asynchronous, so strobes must also drop combinationally.
      if (rst) begin
         imem_req = 1'b0;
         dmem_req = 1'b0;
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         PCSrc    = 1'b0;
         Branch   = 1'b0;
         MemRead  = 1'b0;
         MemtoReg = 1'b0;
         MemWrite = 1'b0;
         ALUSrc   = 1'b0;
         RegWrite = 1'b0;
         ALUOp    = 2'b00;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_cls     <= C_R;
         r_instret <= '0;
         r_wait    <= 8'd0;
         r_illegal <= 1'b0;
         r_tmo     <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE && !stall_in && w_dec_ok) r_cls <= w_dec_cls;
         if (w_retire) r_instret <= r_instret + CNT_W'(1);
         if (w_set_ill) r_illegal <= 1'b1;
         if (w_set_tmo) r_tmo <= 1'b1;
         if ((r_state == S_FETCH || r_state == S_MEM) && w_next == r_state && !w_ready)
            r_wait <= r_wait + 8'd1;
         else
            r_wait <= 8'd0;
      end
   end

   assign instret     = r_instret;
   assign illegal     = r_illegal;
   assign mem_timeout = r_tmo;
   assign state       = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction timing model builds expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;
   localparam int CNT_W = 4;
   localparam int T     = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [6:0] opcode = 7'd0;
   logic branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0, stall_in = 1'b0;
   logic imem_req, dmem_req, IRWrite, PCWrite, PCSrc, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
   logic [1:0] ALUOp;
   logic [CNT_W-1:0] instret;
   logic illegal, mem_timeout;
   logic [2:0] state;

   multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .stall_in(stall_in),
      .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .PCSrc(PCSrc), .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
      .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp),
      .instret(instret), .illegal(illegal), .mem_timeout(mem_timeout), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]       st;
      logic             ireq, dreq, irw, pcw, pcsrc, br, mrd, m2r, mwr, asrc, rw;
      logic [1:0]       aop;
      logic [CNT_W-1:0] cnt;
      logic             ill, tmo;
   } obs_t;

   typedef struct packed {
      logic       imr, dmr, stall, bt, rs;
      logic [6:0] op;
      obs_t       e;
   } cyc_t;

   localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4;

   obs_t exp_q[$];
   cyc_t plan[$];
   int checks = 0;
   int errors = 0;
   int cycno  = 0;
   logic [CNT_W-1:0] m_instret = '0;
   logic m_ill = 1'b0, m_tmo = 1'b0;

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic int classify(input logic [6:0] op);
      case (op)
         7'b0110011: return K_R;
         7'b0010011: return K_I;
         7'b0000011: return K_LD;
         7'b0100011: return K_ST;
         7'b1100011: return K_BR;
         default:    return -1;
      endcase
   endfunction

   function automatic obs_t base(input logic [2:0] st);
      obs_t e;
      e     = '0;
      e.st  = st;
      e.cnt = m_instret;
      e.ill = m_ill;
      e.tmo = m_tmo;
      return e;
   endfunction

   task automatic add(input logic imr, input logic dmr, input logic stall, input logic bt,
                      input logic [6:0] op, input obs_t e);
      cyc_t c;
      c.imr = imr; c.dmr = dmr; c.stall = stall; c.bt = bt; c.rs = 1'b0; c.op = op; c.e = e;
      plan.push_back(c);
   endtask

   task automatic add_reset();
      cyc_t c;
      m_instret = '0;
      m_ill     = 1'b0;
      m_tmo     = 1'b0;
      c.imr = rb(); c.dmr = rb(); c.stall = rb(); c.bt = rb(); c.rs = 1'b1; c.op = 7'd0;
      c.e = base(3'd0);
      plan.push_back(c);
   endtask

   task automatic add_trap(input int n);
      for (int k = 0; k < n; k++) add(rb(), rb(), rb(), rb(), 7'h7f, base(3'd5));
      add_reset();
   endtask

   task automatic add_wb(input int sw, input int cls, input logic bt, input logic [6:0] op);
      obs_t e;
      for (int k = 0; k <= sw; k++) begin
         e = base(3'd4);
         e.m2r = (cls == K_LD);
         if (k == sw) begin e.rw = 1'b1; e.pcw = 1'b1; end
         add(rb(), rb(), k < sw, bt, op, e);
      end
      m_instret++;
   endtask

   task automatic drive_plan();
      foreach (plan[i]) begin
         @(posedge clk);
         #1;
         imem_ready   = plan[i].imr;
         dmem_ready   = plan[i].dmr;
         stall_in     = plan[i].stall;
         branch_taken = plan[i].bt;
         opcode       = plan[i].op;
         rst          = plan[i].rs;
         exp_q.push_back(plan[i].e);
      end
   endtask

   // One instruction: imem/dmem wait cycles, stall cycles in DECODE/EXEC/WB, optional reset at plan index abort_at.
   task automatic run_instr(input logic [6:0] op, input int di, input int dd, input int sd,
                            input int se, input int sw, input logic bt, input int abort_at);
      obs_t e;
      int cls;
      plan.delete();
      cls = classify(op);
      for (int k = 0; k < di && k < T; k++) begin
         e = base(3'd0); e.ireq = 1'b1;
         add(1'b0, rb(), rb(), bt, op, e);
      end
      if (di >= T) begin
         m_tmo = 1'b1;
         add_trap(4);
      end else begin
         e = base(3'd0); e.ireq = 1'b1; e.irw = 1'b1;
         add(1'b1, rb(), rb(), bt, op, e);
         for (int k = 0; k <= sd; k++) add(rb(), rb(), k < sd, bt, op, base(3'd1));
         if (cls < 0) begin
            m_ill = 1'b1;
            add_trap(22);
         end else begin
            for (int k = 0; k <= se; k++) begin
               e = base(3'd2);
               case (cls)
                  K_R:  e.aop = 2'b10;
                  K_I:  begin e.asrc = 1'b1; e.aop = 2'b10; end
                  K_BR: begin
                     e.aop = 2'b01; e.pcsrc = bt;
                     if (k == se) begin e.br = 1'b1; e.pcw = 1'b1; end
                  end
                  default: e.asrc = 1'b1;
               endcase
               add(rb(), rb(), k < se, bt, op, e);
            end
            if (cls == K_BR) begin
               m_instret++;
            end else if (cls == K_LD || cls == K_ST) begin
               for (int k = 0; k < dd && k < T; k++) begin
                  e = base(3'd3); e.dreq = 1'b1; e.asrc = 1'b1;
                  e.mrd = (cls == K_LD); e.mwr = (cls == K_ST);
                  add(rb(), 1'b0, rb(), bt, op, e);
               end
               if (dd >= T) begin
                  m_tmo = 1'b1;
                  add_trap(4);
               end else begin
                  e = base(3'd3); e.dreq = 1'b1; e.asrc = 1'b1;
                  e.mrd = (cls == K_LD); e.mwr = (cls == K_ST); e.pcw = (cls == K_ST);
                  add(rb(), 1'b1, rb(), bt, op, e);
                  if (cls == K_ST) m_instret++;
                  else add_wb(sw, cls, bt, op);
               end
            end else begin
               add_wb(sw, cls, bt, op);
            end
         end
      end
      if (abort_at >= 0 && abort_at < plan.size()) begin
         while (plan.size() > abort_at) void'(plan.pop_back());
         add_reset();
      end
      drive_plan();
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         obs_t ex, ac;
         ex = exp_q.pop_front();
         ac.st = state; ac.ireq = imem_req; ac.dreq = dmem_req; ac.irw = IRWrite; ac.pcw = PCWrite;
         ac.pcsrc = PCSrc; ac.br = Branch; ac.mrd = MemRead; ac.m2r = MemtoReg; ac.mwr = MemWrite;
         ac.asrc = ALUSrc; ac.rw = RegWrite; ac.aop = ALUOp; ac.cnt = instret;
         ac.ill = illegal; ac.tmo = mem_timeout;
         checks++;
         if (ac !== ex) begin
            errors++;
            $display("FAIL cycle_outputs cyc=%0d: got st=%0d strobes=%b aop=%b instret=%0d ill=%b tmo=%b, required st=%0d strobes=%b aop=%b instret=%0d ill=%b tmo=%b",
                     cycno, ac.st, {ac.ireq, ac.dreq, ac.irw, ac.pcw, ac.pcsrc, ac.br, ac.mrd, ac.m2r, ac.mwr, ac.asrc, ac.rw},
                     ac.aop, ac.cnt, ac.ill, ac.tmo,
                     ex.st, {ex.ireq, ex.dreq, ex.irw, ex.pcw, ex.pcsrc, ex.br, ex.mrd, ex.m2r, ex.mwr, ex.asrc, ex.rw},
                     ex.aop, ex.cnt, ex.ill, ex.tmo);
         end
         cycno++;
      end
   end

   initial begin
      logic [6:0] op;
      int sel;
      plan.delete();
      add_reset();
      drive_plan();
      // Directed cases
      run_instr(7'b0110011, 0, 0, 0, 0, 0, 1'b0, -1);   // R-type, zero wait
      run_instr(7'b0000011, 0, 3, 0, 0, 0, 1'b0, -1);   // LOAD, dmem 3 late
      run_instr(7'b1100011, 0, 0, 0, 0, 0, 1'b1, -1);   // BR taken
      run_instr(7'b1100011, 0, 0, 0, 0, 0, 1'b0, -1);   // BR not taken
      run_instr(7'b0010011, 0, 0, 0, 0, 0, 1'b0, -1);   // I-type
      run_instr(7'b0100011, 0, 0, 0, 0, 0, 1'b0, -1);   // STORE
      run_instr(7'b1111111, 0, 0, 0, 0, 0, 1'b0, -1);   // illegal
      run_instr(7'b0110011, 15, 0, 0, 0, 0, 1'b0, -1);  // imem timeout
      run_instr(7'b0110011, 14, 0, 0, 0, 0, 1'b0, -1);  // ready on limit cycle
      run_instr(7'b0000011, 0, 15, 0, 0, 0, 1'b0, -1);  // dmem timeout
      run_instr(7'b0000011, 0, 14, 0, 0, 0, 1'b0, -1);  // dmem ready on limit cycle
      run_instr(7'b0100011, 0, 3, 0, 5, 0, 1'b0, 9);    // STORE stalled in EXEC, reset in MEM
      run_instr(7'b0110011, 1, 0, 2, 2, 3, 1'b1, -1);   // stalls in DECODE/EXEC/WB
      // Randomized instruction stream
      repeat (300) begin
         sel = $urandom_range(0, 11);
         case (sel)
            0, 1:    op = 7'b0110011;
            2, 3:    op = 7'b0010011;
            4, 5:    op = 7'b0000011;
            6, 7:    op = 7'b0100011;
            8, 9:    op = 7'b1100011;
            default: op = 7'($urandom_range(0, 127));
         endcase
         run_instr(op,
                   ($urandom_range(0, 14) == 0) ? $urandom_range(10, 16) : $urandom_range(0, 2),
                   ($urandom_range(0, 14) == 0) ? $urandom_range(10, 16) : $urandom_range(0, 2),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                   rb(),
                   ($urandom_range(0, 19) == 0) ? $urandom_range(0, 8) : -1);
      end
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style multi-cycle sequencer for the RV32I core, replacing single-cycle decode.
- Steps each instruction through FETCH / DECODE / EXEC / MEM / WB.
- Handshakes with the instruction and data memories, and drives the existing datapath strobes (Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite) plus the IR and PC write enables.
- Counts retired instructions and traps on illegal opcodes or memory timeouts.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- MEM_TIMEOUT, 15: maximum consecutive wait cycles for imem_ready or dmem_ready before trapping. Legal range is 1..255.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  instr[6:0] from the IR output; valid from DECODE onward
- branch_taken  in  1  ALU branch-compare result, sampled in EXEC
- imem_ready  in  1  instruction memory has data this cycle
- dmem_ready  in  1  data memory has completed the access this cycle
- stall_in  in  1  external freeze request
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- IRWrite  out  1  load the IR
- PCWrite  out  1  update the PC
- PCSrc  out  1  0 = PC+4, 1 = branch target
- Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite  out  1 each  datapath strobes
- ALUOp  out  2  00 = add, 01 = branch compare, 10 = funct decode
- instret  out  CNT_W  retired-instruction count
- illegal  out  1  sticky: illegal opcode trap
- mem_timeout  out  1  sticky: memory timeout trap
- state  out  3  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Encodings 6 and 7 go to TRAP.
- Class register cls, 3 bits, loaded in DECODE from opcode:
  - R = 0110011
  - I = 0010011
  - LOAD = 0000011
  - STORE = 0100011
  - BR = 1100011
  - anything else is illegal
- Reset (asynchronous, while rst=1):
  - state=FETCH, cls=R, instret=0, wait counter=0, illegal=0, mem_timeout=0.
  - All strobes are gated to 0 while rst=1, including imem_req.
- FETCH:
  - imem_req=1.
  - imem_ready=1: IRWrite=1 in the same cycle, next state DECODE.
  - imem_ready=0: wait counter increments.
- DECODE:
  - Latch cls.
  - Illegal opcode: set illegal, go to TRAP.
  - Otherwise go to EXEC.
- EXEC: drive ALUSrc and ALUOp from cls.
  - R: ALUSrc=0, ALUOp=10.
  - I: ALUSrc=1, ALUOp=10.
  - LOAD/STORE: ALUSrc=1, ALUOp=00.
  - BR: ALUOp=01, Branch=1, PCWrite=1, PCSrc=branch_taken; retire, go to FETCH.
  - R/I go to WB; LOAD/STORE go to MEM.
- MEM:
  - dmem_req=1, ALUSrc=1, ALUOp=00.
  - MemRead=1 for LOAD; MemWrite=1 for STORE.
  - On dmem_ready: LOAD goes to WB; STORE asserts PCWrite=1 (PCSrc=0), retires, goes to FETCH.
- WB:
  - RegWrite=1, MemtoReg=(cls==LOAD), PCWrite=1, PCSrc=0.
  - Retire, go to FETCH.
- Retire: instret increments by 1 in the retiring cycle and wraps modulo 2^CNT_W.
- Wait counter:
  - Counts consecutive not-ready cycles in FETCH and MEM; clears on a ready cycle or a state change.
  - Reaching MEM_TIMEOUT with ready still low: set mem_timeout, go to TRAP.
  - Ready arriving on the same cycle as the limit takes priority (no trap).
- TRAP:
  - All strobes and requests are 0; instret is frozen.
  - Exit only via rst.
- stall_in:
  - Honoured only in DECODE, EXEC and WB. While high, the state holds and all strobes (IRWrite, PCWrite, RegWrite, MemWrite, MemRead, Branch) are forced to 0.
  - Ignored in FETCH and MEM, so a handshake is never dropped.
- Output timing: all outputs are combinational from state and cls, except:
  - IRWrite depends on imem_ready;
  - PCSrc depends on branch_taken;
  - MEM/STORE PCWrite depends on dmem_ready.
- Latency with zero-wait memory:
  - BR: 3 cycles
  - R/I: 4 cycles
  - STORE: 4 cycles
  - LOAD: 5 cycles
- rst mid-instruction: aborts immediately; no strobe is asserted after rst rises.

Test Plan:
- R-type add (0110011), ready tied high: state sequence 0→1→2→4→0; RegWrite=1 only in WB; instret 0→1 after 4 cycles.
- LOAD with dmem_ready delayed 3 cycles:
  - MEM held for 4 cycles, MemRead=1 throughout;
  - WB shows MemtoReg=1, RegWrite=1;
  - instret +1 after 8 cycles total.
- BR with branch_taken=1, then a BR with branch_taken=0: EXEC shows PCWrite=1 and PCSrc=1, then PCSrc=0; RegWrite stays 0; 3 cycles each.
- Opcode 1111111: illegal=1 from the cycle after DECODE; state=5 and all strobes 0 for 20+ cycles; rst clears illegal to 0 and state to 0.
- imem_ready held low with MEM_TIMEOUT=15: mem_timeout=1 and state=5 after 15 cycles. A repeat run with ready arriving on cycle 15 gives no trap and moves to DECODE.
- stall_in=1 for 5 cycles in EXEC of a STORE: state stays 2 with strobes 0, then proceeds to MEM. Asserting rst during MEM gives dmem_req=0 immediately and state=0.
